if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction fetch stage that produces the `Instruction` / `Pcmas4_In` pair consumed by the IF/ID pipeline register.
- Owns the program counter and runs a req/ack handshake with instruction memory.
- Buffers one response while the decode side is stalled.
- Discards in-flight fetches on a branch redirect.
- Sits between the instruction ROM/cache and `REG_IF_ID`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `imem_req  out  1`: fetch request; held until `imem_ack`.
- `imem_addr  out  32`: fetch address; stable while `imem_req`=1 and no ack.
- `imem_ack  in  1`: one-cycle response strobe; `imem_rdata` valid this cycle.
- `imem_rdata  in  32`: fetched instruction word.
- `stall  in  1`: decode not accepting; output must hold.
- `redirect  in  1`: taken branch/jump; flush and refetch.
- `redirect_pc  in  32`: target address, sampled when `redirect`=1.
- `Instruction  out  32`: to IF/ID `Instruction`.
- `Pcmas4  out  32`: fetch address + 4, to IF/ID `Pcmas4_In`.
- `valid  out  1`: `Instruction`/`Pcmas4` hold a live instruction.

## Operation
- Registers:
  - `pc`: next address to request.
  - `addr_q`: in-flight address.
  - `skid`: 32-bit data + 32-bit pc+4.
  - Output registers.
- The output slot is consumed in any cycle with `valid`=1 and `stall`=0.
- FSM states: FETCH, HOLD, DRAIN.
- FETCH:
  - `imem_req`=1, `imem_addr`=`addr_q`.
  - On ack with slot free or consumed: load the output with data and `addr_q+4`; `pc`, `addr_q` <= `addr_q+4`.
  - On ack with slot full and `stall`: write to `skid`, go HOLD.
- HOLD:
  - `imem_req`=0.
  - When `stall`=0: `skid` moves to the output; `addr_q` <= `pc`; go FETCH.
- DRAIN:
  - `imem_req`=1, address unchanged.
  - On ack: discard data, `addr_q` <= `pc`, go FETCH.
- Redirect has top priority:
  - `valid` <= 0 next cycle regardless of `stall`.
  - `skid` is dropped and `pc` <= `redirect_pc`.
  - FETCH with ack in the same cycle: drop the data, `addr_q` <= `redirect_pc`, stay FETCH.
  - FETCH with no ack: go DRAIN.
  - HOLD: go FETCH with `addr_q` <= `redirect_pc`.
  - DRAIN: the latest redirect wins.
- Address arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- The low 2 bits of `redirect_pc` are forced to 0.
- No instruction decode here; field extraction (OpCode[31:28], Cond[27:26], F[25:24], Rg[23:20], Rp[19:16], Rs[15:12], Inm[15:0], Label[23:0]) stays in IF/ID.

## Timing
- Reset values:
  - `valid`=0, `Instruction`=0, `Pcmas4`=0, `imem_req`=0.
  - `imem_addr`=`RESET_PC`, `pc`=`RESET_PC`.
  - State = FETCH, `skid` empty.
- First cycle after `rst` falls: `imem_req`=1 at `RESET_PC`.
- Latency: ack in cycle N gives `valid`=1 with that instruction in cycle N+1.
- Zero-wait memory (ack every cycle): one instruction per cycle, addresses +4 each cycle.
- While `stall`=1: `Instruction`, `Pcmas4` and `valid` are unchanged.
- At most one fetch is in flight; at most two instructions are held (output + skid).
- `rst` mid-request: the FSM returns to reset state immediately; a late ack after reset is ignored, because `imem_req`=0 in the reset cycle.
- Redirect in cycle N: first request to the target is at N+1 (FETCH/HOLD) or the cycle after the drain ack (DRAIN).

## Configuration
- `IF_FETCH_STATS_EN` defined: adds ports `fetch_count out 32` and `redirect_count out 32`.
  - `fetch_count` increments on each output-slot load (including skid-to-output).
  - `redirect_count` increments on each `redirect` cycle.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`:
  - FSM state typedef (FETCH/HOLD/DRAIN).
  - Instruction width 32 and PC increment 4.
  - Instruction field bit-position constants shared with IF/ID.
- One sub-module: `if_pc_gen` (pc/`addr_q` registers, +4 adder, redirect mux).
- FSM, skid buffer and output register live in the top.

## Test plan
- Reset release, `RESET_PC`=0, ack every cycle, `rdata`=32'h0001_7000, 32'h1175_B000 -> addrs 0, 4, 8…; outputs (32'h0001_7000, `Pcmas4`=4), then (32'h1175_B000, 8).
- Ack 3 cycles after req -> `imem_addr` stable for all 3 cycles; `valid` rises the cycle after ack.
- `stall`=1 for 4 cycles with zero-wait memory -> output frozen; `imem_req` drops after one skid capture; on release, the skid value appears next, with no skipped or duplicated addresses.
- `redirect`=1, `redirect_pc`=32'h40, with a req at 8 pending and no ack -> DRAIN; the ack at 8 is discarded; next req at 32'h40; `valid`=0 in between.
- Redirect coincident with ack and `stall`=1 -> `valid`=0 next cycle; data dropped; next req at the target.
- `RESET_PC`=32'hFFFF_FFFC -> `Pcmas4`=0; next fetch address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction width, PC step,
// and the instruction field positions decoded downstream in IF/ID.
package cpu_pkg;

    localparam int unsigned INSTR_W       = 32;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Instruction field bit positions (consumed by IF/ID, not by fetch)
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 28;
    localparam int unsigned COND_MSB   = 27;
    localparam int unsigned COND_LSB   = 26;
    localparam int unsigned F_MSB      = 25;
    localparam int unsigned F_LSB      = 24;
    localparam int unsigned RG_MSB     = 23;
    localparam int unsigned RG_LSB     = 20;
    localparam int unsigned RP_MSB     = 19;
    localparam int unsigned RP_LSB     = 16;
    localparam int unsigned RS_MSB     = 15;
    localparam int unsigned RS_LSB     = 12;
    localparam int unsigned INM_MSB    = 15;
    localparam int unsigned INM_LSB    = 0;
    localparam int unsigned LABEL_MSB  = 23;
    localparam int unsigned LABEL_LSB  = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Next sequential address; wraps modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

    // Force word alignment of a jump target
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode-side
// control (stall/redirect) and the IF/ID output slot.
interface if_fetch_unit_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [INSTR_W-1:0] Instruction;
    logic [31:0]        Pcmas4;
    logic               valid;

    modport master (
        output imem_req, imem_addr, Instruction, Pcmas4, valid,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, Instruction, Pcmas4, valid,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/if_pc_gen.sv
// Program counter generator: holds pc (next address to request) and
// addr_q (address currently on the memory bus), the +4 adder and the
// redirect mux. Sequencing decisions come from the fetch FSM.
module if_pc_gen
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_adv,
    input  logic        i_skid,
    input  logic        i_addr_from_pc,
    input  logic        i_addr_from_tgt,
    output logic [31:0] o_pc,
    output logic [31:0] o_addr_q,
    output logic [31:0] o_addr_plus4
);

    logic [31:0] r_pc;
    logic [31:0] r_addr_q;
    logic [31:0] w_addr_plus4;
    logic [31:0] w_tgt;

    assign w_addr_plus4 = pc_plus4(r_addr_q);
    assign w_tgt        = align_pc(i_redirect_pc);
    assign o_pc         = r_pc;
    assign o_addr_q     = r_addr_q;
    assign o_addr_plus4 = w_addr_plus4;

    // pc / addr_q update: redirect target beats sequential advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_addr_q <= RESET_PC;
        end else begin
            if (i_redirect) begin
                r_pc <= w_tgt;
            end else if (i_adv || i_skid) begin
                r_pc <= w_addr_plus4;
            end else begin
                r_pc <= r_pc;
            end

            if (i_addr_from_tgt) begin
                r_addr_q <= w_tgt;
            end else if (i_addr_from_pc) begin
                r_addr_q <= r_pc;
            end else if (i_adv) begin
                r_addr_q <= w_addr_plus4;
            end else begin
                r_addr_q <= r_addr_q;
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding REG_IF_ID. Owns the fetch FSM, a
// one-entry skid buffer and the registered output slot.
// Optional build macro: IF_FETCH_STATS_EN adds fetch_count/redirect_count.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_unit_if.master   bus
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       redirect_count
`endif
);

    fetch_state_e       r_state;
    fetch_state_e       w_next_state;
    logic               r_req;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [31:0]        r_pcmas4;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [31:0]        r_skid_pcmas4;

    logic [31:0] w_pc;
    logic [31:0] w_addr_q;
    logic [31:0] w_addr_plus4;
    logic        w_ack;
    logic        w_slot_free;
    logic        w_consume;
    logic        w_adv;
    logic        w_skid_wr;
    logic        w_addr_from_pc;
    logic        w_addr_from_tgt;
    logic        w_out_ld_mem;
    logic        w_out_ld_skid;
    logic        w_clr_valid;

    // An ack only counts while a request is actually being driven; this
    // makes a late ack arriving right after reset harmless.
    assign w_ack       = bus.imem_ack & r_req;
    assign w_consume   = r_valid & ~bus.stall;
    assign w_slot_free = ~r_valid | ~bus.stall;

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = w_addr_q;
    assign bus.Instruction = r_instr;
    assign bus.Pcmas4      = r_pcmas4;
    assign bus.valid       = r_valid;

    if_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk             (clk),
        .rst             (rst),
        .i_redirect      (bus.redirect),
        .i_redirect_pc   (bus.redirect_pc),
        .i_adv           (w_adv),
        .i_skid          (w_skid_wr),
        .i_addr_from_pc  (w_addr_from_pc),
        .i_addr_from_tgt (w_addr_from_tgt),
        .o_pc            (w_pc),
        .o_addr_q        (w_addr_q),
        .o_addr_plus4    (w_addr_plus4)
    );

    // State register; the request line is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_req   <= (w_next_state != ST_HOLD);
        end
    end

    // Next-state and datapath control; redirect overrides everything
    always_comb begin
        w_next_state    = r_state;
        w_adv           = 1'b0;
        w_skid_wr       = 1'b0;
        w_addr_from_pc  = 1'b0;
        w_addr_from_tgt = 1'b0;
        w_out_ld_mem    = 1'b0;
        w_out_ld_skid   = 1'b0;
        w_clr_valid     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (bus.redirect) begin
                    w_clr_valid = 1'b1;
                    if (w_ack || !r_req) begin
                        // Nothing left outstanding: go straight to target
                        w_addr_from_tgt = 1'b1;
                        w_next_state    = ST_FETCH;
                    end else begin
                        // A request is in flight; wait for its ack first
                        w_next_state = ST_DRAIN;
                    end
                end else if (w_ack) begin
                    if (w_slot_free) begin
                        w_out_ld_mem = 1'b1;
                        w_adv        = 1'b1;
                    end else begin
                        w_skid_wr    = 1'b1;
                        w_next_state = ST_HOLD;
                    end
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (bus.redirect) begin
                    w_clr_valid     = 1'b1;
                    w_addr_from_tgt = 1'b1;
                    w_next_state    = ST_FETCH;
                end else if (!bus.stall) begin
                    w_out_ld_skid  = 1'b1;
                    w_addr_from_pc = 1'b1;
                    w_next_state   = ST_FETCH;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                w_clr_valid = bus.redirect;
                if (w_ack) begin
                    w_next_state = ST_FETCH;
                    if (bus.redirect) begin
                        w_addr_from_tgt = 1'b1;
                    end else begin
                        w_addr_from_pc = 1'b1;
                    end
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Output slot: flush, load from memory or skid, or retire on consume
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_instr  <= {INSTR_W{1'b0}};
            r_pcmas4 <= 32'h0000_0000;
        end else if (w_clr_valid) begin
            r_valid  <= 1'b0;
        end else if (w_out_ld_mem) begin
            r_valid  <= 1'b1;
            r_instr  <= bus.imem_rdata;
            r_pcmas4 <= w_addr_plus4;
        end else if (w_out_ld_skid) begin
            r_valid  <= 1'b1;
            r_instr  <= r_skid_instr;
            r_pcmas4 <= r_skid_pcmas4;
        end else if (w_consume) begin
            r_valid  <= 1'b0;
        end else begin
            r_valid  <= r_valid;
        end
    end

    // Skid buffer captures the one response that arrives while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_instr  <= {INSTR_W{1'b0}};
            r_skid_pcmas4 <= 32'h0000_0000;
        end else if (w_skid_wr) begin
            r_skid_instr  <= bus.imem_rdata;
            r_skid_pcmas4 <= w_addr_plus4;
        end else begin
            r_skid_instr  <= r_skid_instr;
            r_skid_pcmas4 <= r_skid_pcmas4;
        end
    end

`ifdef IF_FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_redirect_count;

    assign fetch_count    = r_fetch_count;
    assign redirect_count = r_redirect_count;

    // Event counters: output-slot loads and redirect cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count    <= 32'h0000_0000;
            r_redirect_count <= 32'h0000_0000;
        end else begin
            if (w_out_ld_mem || w_out_ld_skid) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                r_fetch_count <= r_fetch_count;
            end
            if (bus.redirect) begin
                r_redirect_count <= r_redirect_count + 32'd1;
            end else begin
                r_redirect_count <= r_redirect_count;
            end
        end
    end
`endif

endmodule
